// File: rtl/alu_nibble_sequencer.sv
// Runs a single 4-bit 74181-style ALU slice serially over NIBBLES nibbles, LSB first,
// rippling each slice's carry into the next and assembling the wide result and A=B flag.
module alu_nibble_sequencer #(
    parameter int unsigned NIBBLES    = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic [3:0]           op_s,
    input  logic                 op_m,
    input  logic                 op_cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 a_eq_b,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_cin,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cout,
    input  logic                 alu_aeqb
);

    localparam int unsigned W       = 4 * NIBBLES;
    localparam logic [2:0]  LastIdx = 3'(NIBBLES - 1);
    localparam logic [3:0]  InvMask = ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StFinish} state_e;

    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic           eq_q, eq_d;
    logic [3:0]     alu_a_q, alu_a_d;
    logic [3:0]     alu_b_q, alu_b_d;
    logic [3:0]     alu_s_q, alu_s_d;
    logic           alu_m_q, alu_m_d;
    logic           alu_cin_q, alu_cin_d;

    function automatic logic [3:0] nib(input logic [W-1:0] v, input logic [2:0] i);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < int'(NIBBLES); k++) begin
            if (i == 3'(k)) r = v[4*k +: 4];
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        carry_d   = carry_q;
        eq_d      = eq_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_s_d   = alu_s_q;
        alu_m_d   = alu_m_q;
        alu_cin_d = alu_cin_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // The drive registers double as the latched S/M copies.
                    a_d       = op_a;
                    b_d       = op_b;
                    idx_d     = 3'd0;
                    busy_d    = 1'b1;
                    alu_a_d   = op_a[3:0] ^ InvMask;
                    alu_b_d   = op_b[3:0] ^ InvMask;
                    alu_s_d   = op_s;
                    alu_m_d   = op_m;
                    alu_cin_d = op_cin;
                    state_d   = StDrive;
                end
            end
            StDrive: begin
                state_d = StSample;
            end
            StSample: begin
                for (int k = 0; k < int'(NIBBLES); k++) begin
                    if (idx_q == 3'(k)) result_d[4*k +: 4] = alu_f ^ InvMask;
                end
                carry_d = alu_cout;
                eq_d    = (idx_q == 3'd0) ? alu_aeqb : (eq_q & alu_aeqb);
                if (idx_q == LastIdx) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StFinish;
                end else begin
                    idx_d     = idx_q + 3'd1;
                    alu_a_d   = nib(a_q, idx_q + 3'd1) ^ InvMask;
                    alu_b_d   = nib(b_q, idx_q + 3'd1) ^ InvMask;
                    alu_cin_d = alu_cout;
                    state_d   = StDrive;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            a_q       <= '0;
            b_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            eq_q      <= 1'b0;
            alu_a_q   <= 4'h0;
            alu_b_q   <= 4'h0;
            alu_s_q   <= 4'h0;
            alu_m_q   <= 1'b0;
            alu_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            eq_q      <= eq_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_s_q   <= alu_s_d;
            alu_m_q   <= alu_m_d;
            alu_cin_q <= alu_cin_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign a_eq_b    = eq_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign alu_m     = alu_m_q;
    assign alu_cin   = alu_cin_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: two instances (4 nibbles active-low, 1 nibble active-high),
// each driving a pin-level 74181 model; expected results are hand-computed constants.
module tb_alu_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-nibble, active-low instance
    logic        start4 = 1'b0;
    logic [15:0] op_a4 = '0, op_b4 = '0;
    logic [3:0]  op_s4 = '0;
    logic        op_m4 = 1'b0, op_cin4 = 1'b0;
    logic        busy4, done4, carry_out4, a_eq_b4;
    logic [15:0] result4;
    logic [3:0]  alu_a4, alu_b4, alu_s4, alu_f4;
    logic        alu_m4, alu_cin4, alu_cout4, alu_aeqb4;

    // 1-nibble, active-high instance
    logic        start1 = 1'b0;
    logic [3:0]  op_a1 = '0, op_b1 = '0;
    logic [3:0]  op_s1 = '0;
    logic        op_m1 = 1'b0, op_cin1 = 1'b0;
    logic        busy1, done1, carry_out1, a_eq_b1;
    logic [3:0]  result1;
    logic [3:0]  alu_a1, alu_b1, alu_s1, alu_f1;
    logic        alu_m1, alu_cin1, alu_cout1, alu_aeqb1;

    alu_nibble_sequencer #(.NIBBLES(4), .ACTIVE_LOW(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .op_a(op_a4), .op_b(op_b4), .op_s(op_s4), .op_m(op_m4), .op_cin(op_cin4),
        .busy(busy4), .done(done4), .result(result4), .carry_out(carry_out4), .a_eq_b(a_eq_b4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_s(alu_s4), .alu_m(alu_m4), .alu_cin(alu_cin4),
        .alu_f(alu_f4), .alu_cout(alu_cout4), .alu_aeqb(alu_aeqb4)
    );

    alu_nibble_sequencer #(.NIBBLES(1), .ACTIVE_LOW(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .op_a(op_a1), .op_b(op_b1), .op_s(op_s1), .op_m(op_m1), .op_cin(op_cin1),
        .busy(busy1), .done(done1), .result(result1), .carry_out(carry_out1), .a_eq_b(a_eq_b1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_m(alu_m1), .alu_cin(alu_cin1),
        .alu_f(alu_f1), .alu_cout(alu_cout1), .alu_aeqb(alu_aeqb1)
    );

    // Pin-level 74181: cn/cout pins high mean "no carry" in active-high data terms.
    function automatic logic [5:0] alu181(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s, input logic m, input logic cn);
        logic [3:0] f;
        logic c, np, ng;
        c = ~cn;
        for (int i = 0; i < 4; i++) begin
            np   = ~(a[i] | (b[i] & s[0]) | (~b[i] & s[1]));
            ng   = ~((a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]));
            f[i] = np ^ ng ^ (m | c);
            c    = ~ng | (~np & c);
        end
        return {&f, ~c, f};
    endfunction

    always_comb {alu_aeqb4, alu_cout4, alu_f4} = alu181(alu_a4, alu_b4, alu_s4, alu_m4, alu_cin4);
    always_comb {alu_aeqb1, alu_cout1, alu_f1} = alu181(alu_a1, alu_b1, alu_s1, alu_m1, alu_cin1);

    logic        use1 = 1'b0;
    logic        done_sel, busy_sel, cout_sel, eq_sel;
    logic [15:0] res_sel;
    assign done_sel = use1 ? done1 : done4;
    assign busy_sel = use1 ? busy1 : busy4;
    assign cout_sel = use1 ? carry_out1 : carry_out4;
    assign eq_sel   = use1 ? a_eq_b1 : a_eq_b4;
    assign res_sel  = use1 ? {12'h000, result1} : result4;

    typedef struct {
        bit          use1;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  s;
        logic        m;
        logic        cin;
        logic [15:0] res;
        bit          chk_c;
        logic        cout;
        logic        eq;
        int          lat;
    } vec_t;

    vec_t       vecs [11];
    logic [3:0] exp_drv_a [4];
    logic [3:0] exp_drv_b [4];
    logic       exp_drv_c [4];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v, input string name);
        int lat;
        @(negedge clk);
        use1 = v.use1;
        if (v.use1) begin
            op_a1 = v.a[3:0]; op_b1 = v.b[3:0]; op_s1 = v.s; op_m1 = v.m; op_cin1 = v.cin;
            start1 = 1'b1;
        end else begin
            op_a4 = v.a; op_b4 = v.b; op_s4 = v.s; op_m4 = v.m; op_cin4 = v.cin;
            start4 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        // Scramble inputs: only the latched copies may matter now.
        op_a4 = ~v.a; op_b4 = 16'h5A5A; op_s4 = ~v.s; op_m4 = ~v.m; op_cin4 = ~v.cin;
        op_a1 = ~v.a[3:0]; op_b1 = 4'hA; op_s1 = ~v.s; op_m1 = ~v.m; op_cin1 = ~v.cin;
        check({name, " busy"}, 32'(busy_sel), 32'd1);
        lat = 1;
        while (!done_sel && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, v.lat);
        check({name, " result"}, 32'(res_sel), 32'(v.res));
        check({name, " a_eq_b"}, 32'(eq_sel), 32'(v.eq));
        if (v.chk_c) check({name, " carry_out"}, 32'(cout_sel), 32'(v.cout));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nd;
        int first;
        int second;

        vecs[0]  = '{1'b0, 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 16'h2233, 1'b1, 1'b0, 1'b0, 9};
        vecs[1]  = '{1'b0, 16'hA5C3, 16'hFF00, 4'b1001, 1'b1, 1'b0, 16'h5AC3, 1'b0, 1'b0, 1'b0, 9};
        vecs[2]  = '{1'b0, 16'h7E7E, 16'h7E7E, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 9};
        vecs[3]  = '{1'b0, 16'h7E7E, 16'h7E7F, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 9};
        vecs[4]  = '{1'b0, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 9};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 9};
        vecs[6]  = '{1'b0, 16'h9C3B, 16'h0000, 4'b1111, 1'b1, 1'b0, 16'h9C3B, 1'b0, 1'b0, 1'b0, 9};
        vecs[7]  = '{1'b0, 16'h1234, 16'h1234, 4'b1001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 9};
        vecs[8]  = '{1'b1, 16'h0003, 16'h0004, 4'b1110, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 3};
        vecs[9]  = '{1'b1, 16'h0005, 16'h0003, 4'b1001, 1'b0, 1'b1, 16'h0008, 1'b1, 1'b1, 1'b0, 3};
        vecs[10] = '{1'b1, 16'h000F, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 3};

        exp_drv_a = '{4'hB, 4'hC, 4'hD, 4'hE};
        exp_drv_b = '{4'h0, 4'h0, 4'h0, 4'hF};
        exp_drv_c = '{1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset result4", 32'(result4), 32'd0);
        check("reset ctrl4", 32'({busy4, done4, carry_out4, a_eq_b4}), 32'd0);
        check("reset drive4", 32'({alu_a4, alu_b4, alu_s4, alu_m4, alu_cin4}), 32'd0);
        check("reset all1", 32'({busy1, done1, result1, carry_out1, a_eq_b1, alu_a1}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_row(vecs[i], $sformatf("vec%0d", i));

        // Carry chain and drive values, nibble by nibble
        use1 = 1'b0;
        @(negedge clk);
        op_a4 = 16'h1234; op_b4 = 16'h0FFF; op_s4 = 4'b1001; op_m4 = 1'b0; op_cin4 = 1'b0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("chain alu_s", 32'({alu_s4, alu_m4}), 32'({4'b1001, 1'b0}));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("chain alu_a n%0d", i), 32'(alu_a4), 32'(exp_drv_a[i]));
            check($sformatf("chain alu_b n%0d", i), 32'(alu_b4), 32'(exp_drv_b[i]));
            check($sformatf("chain alu_cin n%0d", i), 32'(alu_cin4), 32'(exp_drv_c[i]));
            @(negedge clk);
            @(negedge clk);
        end
        check("chain done", 32'({done4, busy4}), 32'({1'b1, 1'b0}));
        check("chain result", 32'(result4), 32'h2233);
        repeat (3) @(negedge clk);
        check("idle hold drive", 32'({alu_a4, alu_b4, alu_cin4}), 32'({4'hE, 4'hF, 1'b1}));
        check("idle hold result", 32'({done4, result4}), 32'({1'b0, 16'h2233}));

        // start held for 20 cycles: exactly two operations, 10 cycles apart
        @(negedge clk);
        op_a4 = 16'h1111; op_b4 = 16'h2222; op_s4 = 4'b1001; op_m4 = 1'b0; op_cin4 = 1'b0;
        start4 = 1'b1;
        nd = 0; first = 0; second = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (done4) begin
                nd++;
                if (nd == 1) first = k;
                else if (nd == 2) second = k;
            end
            if (k == 20) start4 = 1'b0;
        end
        check("held start done count", nd, 2);
        check("held start first done", first, 9);
        check("held start spacing", second - first, 10);
        check("held start result", 32'(result4), 32'h3333);

        // start pulse while busy is ignored
        @(negedge clk);
        op_a4 = 16'h0101; op_b4 = 16'h0202; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        start4 = 1'b1;
        op_a4 = 16'hFFFF;
        @(negedge clk);
        start4 = 1'b0;
        nd = 0; first = 0;
        for (int k = 5; k <= 30; k++) begin
            if (done4) begin
                nd++;
                if (first == 0) first = k;
            end
            @(negedge clk);
        end
        check("busy pulse done count", nd, 1);
        check("busy pulse done cycle", first, 9);
        check("busy pulse result", 32'({busy4, result4}), 32'({1'b0, 16'h0303}));

        // Reset during SAMPLE of nibble 2 aborts with no done
        @(negedge clk);
        op_a4 = 16'h1234; op_b4 = 16'h0FFF; op_s4 = 4'b1001; op_m4 = 1'b0; op_cin4 = 1'b0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset partial result", 32'(result4[7:0]), 32'h33);
        rst_n = 1'b0;
        #1;
        check("abort result", 32'(result4), 32'd0);
        check("abort ctrl", 32'({busy4, done4, carry_out4, a_eq_b4}), 32'd0);
        check("abort drive", 32'({alu_a4, alu_b4, alu_s4, alu_m4, alu_cin4}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done4 || busy4) nd++;
        end
        check("abort no done", nd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller that runs one 4-bit 74LS181-style ALU slice serially over NIBBLES nibbles, giving 4*NIBBLES-bit operations.
- Latches the operands and the function (S, M, carry in) on start. Presents one nibble per step, LSB first, and chains each step's carry out into the next step's carry in.
- Assembles the wide result, the final carry and the A=B flag.
- Sits between the calculator control FSM and the single shared ALU instance.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; legal range 1 to 8.
- ACTIVE_LOW, 1, when 1: alu_a and alu_b are driven inverted and alu_f is captured inverted, so the user side is active-high; when 0: data passes straight through.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op_a  in  4*NIBBLES  operand A (user polarity)
- op_b  in  4*NIBBLES  operand B
- op_s  in  4  function select
- op_m  in  1  mode control (1 = logic)
- op_cin  in  1  carry input for nibble 0, passed unmodified in ALU polarity
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; result, carry_out and a_eq_b are valid
- result  out  4*NIBBLES  assembled F
- carry_out  out  1  carry out of the last nibble
- a_eq_b  out  1  AND of every nibble's AEqualsB
- alu_a  out  4  to ALU A
- alu_b  out  4  to ALU B
- alu_s  out  4  to ALU S
- alu_m  out  1  to ALU M
- alu_cin  out  1  to ALU C_in
- alu_f  in  4  from ALU F
- alu_cout  in  1  from ALU C_out
- alu_aeqb  in  1  from ALU AEqualsB

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - busy=0, done=0, result=0, carry_out=0, a_eq_b=0.
  - alu_a, alu_b and alu_s = 0; alu_m=0; alu_cin=0.
  - Nibble index=0.
  - Reset mid-operation aborts the operation immediately; no done pulse is produced.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - When start=1: latch op_a, op_b, op_s, op_m, op_cin; set idx=0; set busy=1; go to DRIVE.
  - When start=0: stay in IDLE.
- DRIVE (one cycle):
  - alu_a and alu_b carry nibble idx of the latched operands, inverted if ACTIVE_LOW=1.
  - alu_s and alu_m carry the latched values.
  - alu_cin = op_cin when idx=0, otherwise the carry captured in the previous SAMPLE.
  - Next state: SAMPLE. The ALU is combinational and gets one full cycle to settle.
- SAMPLE (one cycle):
  - ALU drive outputs are held stable.
  - At the end of the cycle, capture alu_f (inverted if ACTIVE_LOW=1) into result[4*idx+3:4*idx].
  - Capture alu_cout into the carry register.
  - Update the equality accumulator: set to alu_aeqb when idx=0, otherwise AND it with alu_aeqb.
  - If idx=NIBBLES-1, go to FINISH; otherwise idx+1 and go to DRIVE.
- FINISH (one cycle):
  - done=1, busy=0.
  - carry_out and a_eq_b are taken from the registers.
  - Next state: IDLE.
- Latency: done is asserted exactly 2*NIBBLES+1 cycles after the edge that accepts start (9 cycles for NIBBLES=4). Throughput is one operation per 2*NIBBLES+2 cycles.
- The carry is chained in every mode. With M=1 the ALU ignores it, but it is still captured.
- result, carry_out and a_eq_b keep their values until the next operation's SAMPLE cycles overwrite them. result bits are updated nibble by nibble during an operation.
- start while busy=1 (DRIVE, SAMPLE or FINISH) is ignored, not queued. start in the cycle FINISH is active is also ignored; it is accepted on the following cycle in IDLE.
- op_* inputs may change freely after acceptance; only the latched copies are used.
- In IDLE the ALU drive outputs hold their last values (0 after reset).
- NIBBLES=1: DRIVE, then SAMPLE, then FINISH; done 3 cycles after acceptance.

Test Plan:
- Reset during an operation: rst_n=0 while in SAMPLE of nibble 2 -> all outputs 0 immediately; IDLE; no done pulse afterwards.
- Arithmetic chain (NIBBLES=4, ACTIVE_LOW=1, bench 74181 model): op_a=0x1234, op_b=0x0FFF, op_s=4'b1001, op_m=0, op_cin set to the no-carry level -> done 9 cycles later; result=0x2233; carry_out at the no-carry level; alu_cin on nibbles 1 to 3 matches the previous alu_cout.
- Logic op: op_a=0xA5C3, op_b=0xFF00, op_s=4'b1001, op_m=1 -> result=0x5AC3 (A^B); a_eq_b=0.
- Equality: op_a=op_b=0x7E7E with the 74181 A-minus-B-minus-1 code -> a_eq_b=1. Repeat with op_b=0x7E7F -> a_eq_b=0.
- Handshake: start held high for 20 cycles -> exactly two operations, done pulses 10 cycles apart. start pulsed during busy -> ignored.
- NIBBLES=1: op_a=0x3, op_b=0x4, OR function -> result=0x7; done 3 cycles after acceptance.
